// File: rtl/ecc_pkg.sv
// Shared constants, FSM state type and word-slicing helpers for the ECC result serializer.
package ecc_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned COORD_W      = 256;
  localparam int unsigned WORDS_PER_PT = 16;
  localparam int unsigned PT_W         = 2 * COORD_W;
  localparam int unsigned CNT_W        = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Word idx of a {x, y} point, most-significant word first; out-of-range idx gives 0.
  function automatic logic [WORD_W-1:0] pt_word(input logic [PT_W-1:0] pt,
                                                 input logic [CNT_W-1:0] idx);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < int'(WORDS_PER_PT); i++) begin
      if (idx == CNT_W'(i)) w = WORD_W'(pt >> ((WORDS_PER_PT - 1 - i) * WORD_W));
    end
    return w;
  endfunction

`ifdef SERIALIZER_CHECKSUM_EN
  // XOR of all data words of a point.
  function automatic logic [WORD_W-1:0] pt_xor(input logic [PT_W-1:0] pt);
    logic [WORD_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(WORDS_PER_PT); i++) begin
      acc = acc ^ WORD_W'(pt >> (i * WORD_W));
    end
    return acc;
  endfunction
`endif

endpackage

// File: rtl/ecc_result_serializer.sv
// Captures mP / mnP results on valid rising edges and streams them as 32-bit words.
// Optional SERIALIZER_CHECKSUM_EN appends an XOR checksum word to every point.
module ecc_result_serializer
  import ecc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] i_mPx,
  input  logic [COORD_W-1:0] i_mPy,
  input  logic [COORD_W-1:0] i_mnPx,
  input  logic [COORD_W-1:0] i_mnPy,
  input  logic               i_mP_valid,
  input  logic               i_mnP_valid,
  output logic [WORD_W-1:0]  o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_last,
  output logic               o_tag,
  output logic               o_busy,
  output logic               o_overflow
);

`ifdef SERIALIZER_CHECKSUM_EN
  localparam int unsigned WORDS_TOTAL = WORDS_PER_PT + 1;
`else
  localparam int unsigned WORDS_TOTAL = WORDS_PER_PT;
`endif
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS_TOTAL - 1);

  state_t            state, state_n;
  logic              prev_mp, prev_mnp;
  logic [1:0]        slot_full, slot_full_n;
  logic [PT_W-1:0]   slot0, slot1, slot0_n, slot1_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              tag_n, valid_n, last_n, busy_n, ovf_n;
  logic [WORD_W-1:0] data_n;
  logic              ev0, ev1, hs, free0, free1, keep0, keep1;
  logic [PT_W-1:0]   sel_pt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Next state, slot bookkeeping and the next output word, all decided in one place.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    tag_n       = o_tag;
    ev0         = i_mP_valid & ~prev_mp;
    ev1         = i_mnP_valid & ~prev_mnp;
    hs          = o_valid & i_ready;
    free0       = hs & o_last & ~o_tag;
    free1       = hs & o_last & o_tag;
    keep0       = slot_full[0] & ~free0;
    keep1       = slot_full[1] & ~free1;
    slot_full_n = {keep1 | ev1, keep0 | ev0};
    slot0_n     = (ev0 & ~keep0) ? {i_mPx, i_mPy} : slot0;
    slot1_n     = (ev1 & ~keep1) ? {i_mnPx, i_mnPy} : slot1;
    ovf_n       = o_overflow | (ev0 & keep0) | (ev1 & keep1);

    case (state)
      ST_IDLE: begin
        if (|slot_full_n) begin
          state_n = ST_SEND;
          cnt_n   = '0;
          tag_n   = ~slot_full_n[0];
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (o_last) begin
            if (|slot_full_n) begin
              cnt_n = '0;
              tag_n = ~slot_full_n[0];
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    sel_pt = tag_n ? slot1_n : slot0_n;
    data_n = pt_word(sel_pt, cnt_n);
`ifdef SERIALIZER_CHECKSUM_EN
    if (cnt_n == LAST_IDX) data_n = pt_xor(sel_pt);
`endif
    valid_n = (state_n == ST_SEND);
    last_n  = valid_n & (cnt_n == LAST_IDX);
    busy_n  = (|slot_full_n) | valid_n;
    if (!valid_n) begin
      data_n = '0;
      tag_n  = 1'b0;
      cnt_n  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_mp    <= 1'b0;
      prev_mnp   <= 1'b0;
      slot_full  <= '0;
      slot0      <= '0;
      slot1      <= '0;
      cnt        <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_tag      <= 1'b0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      prev_mp    <= i_mP_valid;
      prev_mnp   <= i_mnP_valid;
      slot_full  <= slot_full_n;
      slot0      <= slot0_n;
      slot1      <= slot1_n;
      cnt        <= cnt_n;
      o_data     <= data_n;
      o_valid    <= valid_n;
      o_last     <= last_n;
      o_tag      <= tag_n;
      o_busy     <= busy_n;
      o_overflow <= ovf_n;
    end
  end

endmodule

// File: tb/tb_ecc_result_serializer.sv
// Self-checking bench for ecc_result_serializer: directed table, corner sequences, random traffic.
module tb_ecc_result_serializer;

`ifdef SERIALIZER_CHECKSUM_EN
  localparam int NW = 17;
`else
  localparam int NW = 16;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] mpx, mpy, mnpx, mnpy;
  logic         mpv, mnpv, rdy;
  logic [31:0]  o_data;
  logic         o_valid, o_last, o_tag, o_busy, o_overflow;

  always #5 clk = ~clk;

  ecc_result_serializer dut (
    .clk(clk), .rst(rst),
    .i_mPx(mpx), .i_mPy(mpy), .i_mnPx(mnpx), .i_mnPy(mnpy),
    .i_mP_valid(mpv), .i_mnP_valid(mnpv),
    .o_data(o_data), .o_valid(o_valid), .i_ready(rdy),
    .o_last(o_last), .o_tag(o_tag), .o_busy(o_busy), .o_overflow(o_overflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        tag;
    logic        last;
    int          cyc;
  } obs_t;
  obs_t obs[$];

  typedef struct {
    logic [255:0] x;
    logic [255:0] y;
    bit           tag;
    logic [31:0]  w7;
    logic [31:0]  w15;
  } vec_t;
  vec_t vt[3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: word i of a point is x MS-first, then y MS-first, then optional XOR of all 16.
  function automatic logic [31:0] exp_word(input logic [255:0] x, input logic [255:0] y, input int i);
    logic [31:0] acc;
    if (i < 8) return 32'(x >> (32 * (7 - i)));
    if (i < 16) return 32'(y >> (32 * (15 - i)));
    acc = '0;
    for (int j = 0; j < 16; j++) acc = acc ^ exp_word(x, y, j);
    return acc;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake recorder and stall-stability checker.
  logic        stall_prev = 1'b0;
  logic [31:0] held_data;
  logic        held_tag, held_last;
  always @(negedge clk) begin
    if (rst) begin
      if (stall_prev)
        chk("stall_hold", 64'({o_valid, o_data, o_tag, o_last}),
            64'({1'b1, held_data, held_tag, held_last}));
      if (o_valid && rdy) obs.push_back('{o_data, o_tag, o_last, cyc});
    end
    stall_prev <= rst && o_valid && !rdy;
    held_data  <= o_data;
    held_tag   <= o_tag;
    held_last  <= o_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input bit m, input bit n, input logic [255:0] ax, input logic [255:0] ay,
                      input logic [255:0] bx, input logic [255:0] by);
    mpx = ax; mpy = ay; mnpx = bx; mnpy = by;
    mpv = m; mnpv = n;
    tick();
    mpv = 1'b0; mnpv = 1'b0;
  endtask

  task automatic drain(input int mode);
    int k = 0;
    while (o_busy && k < 3000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ~rdy;
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      tick();
      k++;
    end
    rdy = 1'b1;
    chk("drain_idle", 64'(o_busy), 64'(0));
  endtask

  task automatic wait_count(input int n);
    int k = 0;
    while (obs.size() < n && k < 200) begin
      tick();
      k++;
    end
    chk("wait_count", 64'(obs.size() >= n), 64'(1));
  endtask

  task automatic check_point(input logic [255:0] x, input logic [255:0] y, input bit tag, input string nm);
    obs_t o;
    for (int i = 0; i < NW; i++) begin
      if (obs.size() == 0) begin
        chk($sformatf("%s_missing_w%0d", nm, i), 64'(0), 64'(1));
        return;
      end
      o = obs.pop_front();
      chk($sformatf("%s_w%0d", nm, i), 64'({o.data, o.tag, o.last}),
          64'({exp_word(x, y, i), tag, (i == NW - 1)}));
    end
  endtask

  logic [255:0] ax, ay, bx, by;
  int sel;

  initial begin
    vt[0] = '{{224'h0, 32'hDFA978E7}, {224'h0, 32'hF6A1A9BB}, 1'b0, 32'hDFA978E7, 32'hF6A1A9BB};
    vt[1] = '{256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888,
              256'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3_E4E4E4E4_F5F5F5F5_06060606_F00DCAFE,
              1'b1, 32'h88888888, 32'hF00DCAFE};
    vt[2] = '{256'hFFFFFFFF_00000000_FFFFFFFF_00000000_AAAAAAAA_55555555_DEADBEEF_12345678,
              256'h00000001_00000002_00000004_00000008_00000010_00000020_00000040_CAFEBABE,
              1'b0, 32'h12345678, 32'hCAFEBABE};

    rst = 1'b1; mpv = 1'b0; mnpv = 1'b0; rdy = 1'b1;
    mpx = '0; mpy = '0; mnpx = '0; mnpy = '0;
    #1 rst = 1'b0;
    #2;
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_data", 64'(o_data), 64'(0));
    chk("rst_last", 64'(o_last), 64'(0));
    chk("rst_tag", 64'(o_tag), 64'(0));
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_ovf", 64'(o_overflow), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Directed table: single points with full-rate sink.
    for (int v = 0; v < 3; v++) begin
      chk($sformatf("tbl%0d_pre_valid", v), 64'(o_valid), 64'(0));
      fire(!vt[v].tag, vt[v].tag, vt[v].x, vt[v].y, vt[v].x, vt[v].y);
      chk($sformatf("tbl%0d_latency", v), 64'(o_valid), 64'(1));
      chk($sformatf("tbl%0d_tag", v), 64'(o_tag), 64'(vt[v].tag));
      drain(0);
      if (obs.size() >= 16) begin
        chk($sformatf("tbl%0d_w7", v), 64'(obs[7].data), 64'(vt[v].w7));
        chk($sformatf("tbl%0d_w15", v), 64'(obs[15].data), 64'(vt[v].w15));
      end else begin
        chk($sformatf("tbl%0d_count", v), 64'(obs.size()), 64'(NW));
      end
      check_point(vt[v].x, vt[v].y, vt[v].tag, $sformatf("tbl%0d", v));
    end

    // Sink toggling ready every cycle.
    ax = rand256(); ay = rand256();
    fire(1'b1, 1'b0, ax, ay, '0, '0);
    drain(1);
    check_point(ax, ay, 1'b0, "toggle");
    chk("toggle_extra", 64'(obs.size()), 64'(0));

    // Simultaneous capture: mP first, mnP immediately after.
    ax = rand256(); ay = rand256(); bx = rand256(); by = rand256();
    fire(1'b1, 1'b1, ax, ay, bx, by);
    drain(0);
    if (obs.size() == 2 * NW) chk("simul_gap", 64'(obs[NW].cyc - obs[NW - 1].cyc), 64'(1));
    else chk("simul_count", 64'(obs.size()), 64'(2 * NW));
    check_point(ax, ay, 1'b0, "simul_mp");
    check_point(bx, by, 1'b1, "simul_mnp");
    chk("simul_busy", 64'(o_busy), 64'(0));

    // Overflow mid-stream, then a capture exactly on the last-word handshake.
    chk("ovf_pre", 64'(o_overflow), 64'(0));
    ax = rand256(); ay = rand256();
    fire(1'b1, 1'b0, ax, ay, '0, '0);
    wait_count(5);
    fire(1'b1, 1'b0, rand256(), rand256(), '0, '0);
    chk("ovf_set", 64'(o_overflow), 64'(1));
    begin
      int k = 0;
      while (!(o_valid && o_last) && k < 100) begin tick(); k++; end
    end
    chk("ovf_last_seen", 64'(o_last), 64'(1));
    bx = rand256(); by = rand256();
    fire(1'b1, 1'b0, bx, by, '0, '0);
    drain(0);
    if (obs.size() == 2 * NW) chk("ovf_b2b_gap", 64'(obs[NW].cyc - obs[NW - 1].cyc), 64'(1));
    else chk("ovf_count", 64'(obs.size()), 64'(2 * NW));
    check_point(ax, ay, 1'b0, "ovf_first");
    check_point(bx, by, 1'b0, "ovf_onlast");
    chk("ovf_sticky", 64'(o_overflow), 64'(1));

    // Reset mid-stream at word 9, restart with flag already high.
    ax = rand256(); ay = rand256();
    fire(1'b1, 1'b0, ax, ay, '0, '0);
    wait_count(9);
    rst = 1'b0;
    #1;
    chk("midrst_outputs", 64'({o_valid, o_data, o_last, o_tag, o_busy, o_overflow}), 64'(0));
    obs.delete();
    bx = rand256(); by = rand256();
    mpx = bx; mpy = by; mpv = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("relrst_valid", 64'(o_valid), 64'(1));
    drain(0);
    check_point(bx, by, 1'b0, "relrst");
    mpv = 1'b0;
    tick();

    // Randomized traffic with random backpressure.
    for (int it = 0; it < 20; it++) begin
      sel = $urandom_range(1, 3);
      ax = rand256(); ay = rand256(); bx = rand256(); by = rand256();
      rdy = ($urandom_range(0, 1) != 0);
      fire(sel[0], sel[1], ax, ay, bx, by);
      drain(2);
      if (sel[0]) check_point(ax, ay, 1'b0, $sformatf("rnd%0d_mp", it));
      if (sel[1]) check_point(bx, by, 1'b1, $sformatf("rnd%0d_mnp", it));
      chk($sformatf("rnd%0d_extra", it), 64'(obs.size()), 64'(0));
    end

    // Checksum pattern: all ones except word 0 = 3.
    ax = {32'h3, {7{32'h1}}}; ay = {8{32'h1}};
    fire(1'b1, 1'b0, ax, ay, '0, '0);
    drain(0);
`ifdef SERIALIZER_CHECKSUM_EN
    if (obs.size() == 17) chk("csum_w16", 64'({obs[16].data, obs[16].last}), 64'({32'h2, 1'b1}));
    else chk("csum_count", 64'(obs.size()), 64'(17));
`endif
    check_point(ax, ay, 1'b0, "csum");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_result_serializer.md
ECC_RESULT_SERIALIZER -- requirements
Module: ecc_result_serializer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: i_mPx, i_mPy  in  256 each  mP coordinates from the ECC core.
REQ-004 SHALL have ports: i_mnPx, i_mnPy  in  256 each  mnP coordinates from the ECC core.
REQ-005 SHALL have ports: i_mP_valid, i_mnP_valid  in  1 each  level-valid flags from the ECC core, held high for many cycles.
REQ-006 SHALL have ports: o_data  out  32  output word; o_valid  out  1  word valid; i_ready  in  1  sink ready.
REQ-007 SHALL have ports: o_last  out  1  final word of a point; o_tag  out  1  0 = mP, 1 = mnP.
REQ-008 SHALL have ports: o_busy  out  1  any slot full or streaming; o_overflow  out  1  sticky drop flag.

Function
REQ-009 SHALL detect each rising edge of i_mP_valid and i_mnP_valid (flag high, registered previous value low) and treat it as a capture event.
REQ-010 SHALL capture the matching x/y pair into its own 512-bit slot (slot0 = mP, slot1 = mnP) at the clock edge of the event.
REQ-011 SHALL raise o_valid on the cycle after capture when idle; capture-to-first-word latency = 1 cycle.
REQ-012 SHALL stream 16 words per point: words 0-7 = x[255:224] down to x[31:0], then words 8-15 = y, in the same MS-first order.
REQ-013 SHALL advance the word only on o_valid & i_ready; o_data, o_tag and o_last SHALL stay stable while o_valid & !i_ready.
REQ-014 SHALL assert o_last only with the final word of a point; the slot SHALL free on that word's handshake.
REQ-015 SHALL use FSM IDLE -> SEND, with SEND -> SEND on last handshake if another slot is full, SEND -> IDLE otherwise.
REQ-016 SHALL serve slot0 before slot1 when both are full, including simultaneous capture events in one cycle.
REQ-017 SHALL produce back-to-back points with no bubble: the word after o_last SHALL be word 0 of the next point.
REQ-018 SHALL drop a capture event whose slot is full and set o_overflow, held until reset.
REQ-019 SHALL accept the capture instead of dropping it when the event coincides with that slot's last-word handshake.
REQ-020 SHALL set o_busy = slot0 full | slot1 full | state == SEND.

Reset
REQ-021 SHALL, while rst = 0, force o_valid = 0, o_last = 0, o_tag = 0, o_data = 0, o_busy = 0 and o_overflow = 0.
REQ-022 SHALL, while rst = 0, clear both slots, the edge-detect registers, the word counter and the FSM (IDLE).
REQ-023 SHALL abort mid-stream on reset; o_valid SHALL drop asynchronously, with no partial resume.
REQ-024 SHALL detect an edge on a flag that is already high when reset releases, because the previous-value registers reset to 0.

Configuration
REQ-025 SHALL, with SERIALIZER_CHECKSUM_EN defined, append a 17th word per point equal to the XOR of its 16 data words, with o_last on word 16.
REQ-026 SHALL, without SERIALIZER_CHECKSUM_EN, send exactly 16 words per point with o_last on word 15 and no checksum logic.

Structure
REQ-027 SHALL take WORD_W = 32, COORD_W = 256, WORDS_PER_PT = 16 and the FSM state enum from shared package ecc_pkg.
REQ-028 SHALL be a single module; no sub-module.

Verification
REQ-029 SHALL cover: mP x = {7{32'h0}}, 32'hDFA978E7 and y = ..., 32'hF6A1A9BB, with i_mP_valid rising and i_ready = 1 -> o_valid one cycle later, 16 consecutive words, word 7 = DFA978E7, word 15 = F6A1A9BB with o_last, o_tag = 0.
REQ-030 SHALL cover: i_ready toggling 1/0 every cycle -> each word held stable while stalled; 16 handshakes, no loss or duplication.
REQ-031 SHALL cover: i_mP_valid and i_mnP_valid rising in the same cycle -> 16 words with tag 0, then immediately 16 words with tag 1 and no gap; o_busy low afterwards.
REQ-032 SHALL cover: a second mP edge during word 5 of mP -> o_overflow = 1, the second point dropped; an edge on the last handshake -> the point accepted and sent.
REQ-033 SHALL cover: rst asserted at word 9 -> o_valid = 0 immediately, all outputs 0; after release with i_mP_valid held high, a new full 16-word point is sent.
REQ-034 SHALL cover: SERIALIZER_CHECKSUM_EN with all words 32'h1 except word 0 = 32'h3 -> word 16 = 32'h2 with o_last.
